// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, screen codes, IR key codes and tick-period helper for game_flow_ctrl
package game_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_START = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_OVER  = 2'd3;

    typedef enum logic [1:0] {
        START_SCR = 2'd0,
        GAME_SCR  = 2'd1,
        END_SCR   = 2'd2
    } screen_t;

    // Decoded NEC frames from the handheld remote
    localparam logic [31:0] UP      = 32'h00FF_18E7;
    localparam logic [31:0] DOWN    = 32'h00FF_4AB5;
    localparam logic [31:0] LEFT    = 32'h00FF_10EF;
    localparam logic [31:0] RIGHT   = 32'h00FF_5AA5;
    localparam logic [31:0] ENTER   = 32'h00FF_38C7;
    localparam logic [31:0] MENU    = 32'h00FF_A25D;
    localparam logic [31:0] DIGIT_1 = 32'h00FF_30CF;
    localparam logic [31:0] DIGIT_2 = 32'h00FF_629D;
    localparam logic [31:0] DIGIT_3 = 32'h00FF_7A85;
    localparam logic [31:0] DIGIT_4 = 32'h00FF_22DD;
    localparam logic [31:0] DIGIT_5 = 32'h00FF_02FD;
    localparam logic [31:0] DIGIT_6 = 32'h00FF_C23D;
    localparam logic [31:0] DIGIT_7 = 32'h00FF_E01F;
    localparam logic [31:0] DIGIT_8 = 32'h00FF_A857;
    localparam logic [31:0] DIGIT_9 = 32'h00FF_906F;

    function automatic logic [3:0] key_digit(input logic [31:0] key);
        case (key)
            DIGIT_1: return 4'd1;
            DIGIT_2: return 4'd2;
            DIGIT_3: return 4'd3;
            DIGIT_4: return 4'd4;
            DIGIT_5: return 4'd5;
            DIGIT_6: return 4'd6;
            DIGIT_7: return 4'd7;
            DIGIT_8: return 4'd8;
            DIGIT_9: return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    // Only ever called with constant arguments, so it folds away at elaboration
    function automatic logic [31:0] tick_period(input int clk_hz, input int base_hz,
                                                input int step_hz, input int lvl);
        return 32'(clk_hz / (base_hz + step_hz * (lvl - 1)));
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - loadable down-counter emitting a one-cycle tick every `period` enabled cycles
module tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    // cnt==0 means "reload on the next enabled cycle"; that cycle counts as the first of the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (enable) begin
                if (cnt == '0) begin
                    if (period <= CNT_W'(1))
                        tick <= 1'b1;
                    else
                        cnt <= period - CNT_W'(1);
                end else if (cnt == CNT_W'(1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - snake game menu/play/pause/over flow, level select, score and tick timing
// Optional high-score register enabled by defining HIGH_SCORE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int NUM_LEVELS    = 6,
    parameter int DEFAULT_LEVEL = 4,
    parameter int BASE_HZ       = 2,
    parameter int STEP_HZ       = 2,
    parameter int SCORE_W       = 12
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [31:0]        key_word,
    input  logic               key_valid,
    input  logic               food_eaten,
    input  logic               game_over,
    output logic               game_enable,
    output logic               game_tick,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output screen_t            screen
);

    localparam logic [3:0]  MAX_LEVEL   = 4'(NUM_LEVELS);
    localparam logic [3:0]  RESET_LEVEL = 4'(DEFAULT_LEVEL);
    localparam logic [31:0] PERIOD_1 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 1);
    localparam logic [31:0] PERIOD_2 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 2);
    localparam logic [31:0] PERIOD_3 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 3);
    localparam logic [31:0] PERIOD_4 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 4);
    localparam logic [31:0] PERIOD_5 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 5);
    localparam logic [31:0] PERIOD_6 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 6);
    localparam logic [31:0] PERIOD_7 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 7);
    localparam logic [31:0] PERIOD_8 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 8);
    localparam logic [31:0] PERIOD_9 = tick_period(CLK_HZ, BASE_HZ, STEP_HZ, 9);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         digit;
    logic               key_enter;
    logic               key_menu;
    logic [31:0]        period_sel;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] score_nxt;
    logic               tick_en;

    assign digit     = key_digit(key_word);
    assign key_enter = key_valid && (key_word == ENTER);
    assign key_menu  = key_valid && (key_word == MENU);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: if (key_enter) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (game_over)      state_nxt = ST_OVER;
                else if (key_enter) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (key_enter)     state_nxt = ST_PLAY;
                else if (key_menu) state_nxt = ST_START;
            end
            default: if (key_menu) state_nxt = ST_START;
        endcase
    end

    always_comb begin
        case (level)
            4'd1:    period_sel = PERIOD_1;
            4'd2:    period_sel = PERIOD_2;
            4'd3:    period_sel = PERIOD_3;
            4'd4:    period_sel = PERIOD_4;
            4'd5:    period_sel = PERIOD_5;
            4'd6:    period_sel = PERIOD_6;
            4'd7:    period_sel = PERIOD_7;
            4'd8:    period_sel = PERIOD_8;
            4'd9:    period_sel = PERIOD_9;
            default: period_sel = PERIOD_1;
        endcase
    end

    assign score_sum = {1'b0, score} + (SCORE_W+1)'(level);
    assign score_inc = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_comb begin
        score_nxt = score;
        if (state == ST_START && key_enter)
            score_nxt = '0;
        else if (state == ST_PLAY && food_eaten)
            score_nxt = score_inc;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= ST_START;
            level  <= RESET_LEVEL;
            score  <= '0;
            screen <= START_SCR;
        end else begin
            state <= state_nxt;
            score <= score_nxt;
            if (state == ST_START && key_valid && digit != 4'd0 && digit <= MAX_LEVEL)
                level <= digit;
            case (state_nxt)
                ST_START: screen <= START_SCR;
                ST_OVER:  screen <= END_SCR;
                default:  screen <= GAME_SCR;
            endcase
        end
    end

    assign game_enable = (state == ST_PLAY) || (state == ST_PAUSE);

    // The count only advances on cycles that stay in PLAY, so leaving never emits a stray tick
    assign tick_en = (state == ST_PLAY) && (state_nxt == ST_PLAY);

    tick_gen #(
        .CNT_W(32)
    ) u_tick_gen (
        .clk    (CLOCK_50),
        .rst    (reset),
        .enable (tick_en),
        .clear  (state == ST_START),
        .period (period_sel),
        .tick   (game_tick)
    );

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            high_score_q <= '0;
        else if (state == ST_PLAY && state_nxt == ST_OVER && score_nxt > high_score_q)
            high_score_q <= score_nxt;
    end

    assign high_score = high_score_q;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl (12-bit and 4-bit score instances)
module tb_game_flow_ctrl;
    import game_pkg::*;

`ifdef HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [1:0] scr;
        logic       en;
        logic [3:0] lvl;
        logic [11:0] sc;
        logic [11:0] hs;
        logic [3:0] sc4;
        logic       tk;
    } snap_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] key_word = '0;
    logic        key_valid = 1'b0;
    logic        food_eaten = 1'b0;
    logic        game_over = 1'b0;

    logic        game_enable, game_tick;
    logic [3:0]  level;
    logic [11:0] score, high_score;
    screen_t     screen;
    logic        game_enable4, game_tick4;
    logic [3:0]  level4;
    logic [3:0]  score4, high_score4;
    screen_t     screen4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e;
    int r;
    int tick_q[$];
    snap_t snap_q[$];

    game_flow_ctrl #(.CLK_HZ(1000), .NUM_LEVELS(6), .DEFAULT_LEVEL(4),
                     .BASE_HZ(2), .STEP_HZ(2), .SCORE_W(12)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_word(key_word), .key_valid(key_valid),
        .food_eaten(food_eaten), .game_over(game_over), .game_enable(game_enable),
        .game_tick(game_tick), .level(level), .score(score), .high_score(high_score),
        .screen(screen));

    game_flow_ctrl #(.CLK_HZ(1000), .NUM_LEVELS(6), .DEFAULT_LEVEL(4),
                     .BASE_HZ(2), .STEP_HZ(2), .SCORE_W(4)) dut4 (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_word(key_word), .key_valid(key_valid),
        .food_eaten(food_eaten), .game_over(game_over), .game_enable(game_enable4),
        .game_tick(game_tick4), .level(level4), .score(score4), .high_score(high_score4),
        .screen(screen4));

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Monitor: ticks are matched against expected edge numbers, snapshots against expected outputs
    always @(negedge CLOCK_50) begin
        logic [1:0] scr_v;
        snap_t s;
        int exp_t;
        scr_v = screen;
        if (game_tick) begin
            checks++;
            if (tick_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
            end else begin
                exp_t = tick_q.pop_front();
                if (exp_t != cyc) begin
                    failures++;
                    $display("FAIL tick_time: tick at cycle %0d, required %0d", cyc, exp_t);
                end
            end
        end
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            checks++;
            if (scr_v !== s.scr || game_enable !== s.en || level !== s.lvl || score !== s.sc ||
                high_score !== s.hs || score4 !== s.sc4 || game_tick !== s.tk) begin
                failures++;
                $display("FAIL %s: got scr=%0d en=%0b lvl=%0d score=%0d hs=%0d score4=%0d tick=%0b, required scr=%0d en=%0b lvl=%0d score=%0d hs=%0d score4=%0d tick=%0b",
                         s.name, scr_v, game_enable, level, score, high_score, score4, game_tick,
                         s.scr, s.en, s.lvl, s.sc, s.hs, s.sc4, s.tk);
            end
        end
    end

    task automatic snap(input string name, input logic [1:0] scr, input logic en,
                        input logic [3:0] lvl, input int sc, input int hs, input int sc4);
        snap_t s;
        s.name = name; s.scr = scr; s.en = en; s.lvl = lvl;
        s.sc = 12'(sc); s.hs = 12'(hs); s.sc4 = 4'(sc4); s.tk = 1'b0;
        snap_q.push_back(s);
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic key(input logic [31:0] k);
        key_word = k;
        key_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        key_valid = 1'b0;
        key_word = '0;
    endtask

    task automatic pulse(input logic f, input logic g);
        food_eaten = f;
        game_over = g;
        @(posedge CLOCK_50);
        #1;
        food_eaten = 1'b0;
        game_over = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic key_at(input logic [31:0] k, input int t);
        wait_to(t - 1);
        key(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs1;
        int hs2;
        hs1 = HS_EN ? 12 : 0;
        hs2 = HS_EN ? 21 : 0;

        repeat (3) @(posedge CLOCK_50);
        #1;
        snap("reset_state", START_SCR, 1'b0, 4'd4, 0, 0, 0);
        reset = 1'b0;

        // Level 4: period 125, pause at count 60 for 500 cycles, resume needs 65 more
        key(ENTER);
        e = cyc;
        tick_q.push_back(e + 125);
        tick_q.push_back(e + 250);
        snap("play_entry", GAME_SCR, 1'b1, 4'd4, 0, 0, 0);
        key_at(ENTER, e + 311);
        snap("paused", GAME_SCR, 1'b1, 4'd4, 0, 0, 0);
        r = e + 811;
        key_at(ENTER, r);
        tick_q.push_back(r + 65);
        tick_q.push_back(r + 190);
        wait_to(r + 200);
        pulse(1'b0, 1'b1);
        snap("over_from_play", END_SCR, 1'b0, 4'd4, 0, 0, 0);
        key(ENTER);
        key(DIGIT_1);
        snap("over_ignores_keys", END_SCR, 1'b0, 4'd4, 0, 0, 0);
        key(MENU);
        snap("menu_to_start", START_SCR, 1'b0, 4'd4, 0, 0, 0);

        // Level select: 7 exceeds NUM_LEVELS and is dropped
        key(DIGIT_2);
        key(DIGIT_7);
        snap("level_2_select", START_SCR, 1'b0, 4'd2, 0, 0, 0);
        key(ENTER);
        e = cyc;
        tick_q.push_back(e + 250);
        tick_q.push_back(e + 500);
        wait_to(e + 510);
        key(ENTER);
        snap("pause_level2", GAME_SCR, 1'b1, 4'd2, 0, 0, 0);
        key(MENU);
        snap("pause_menu", START_SCR, 1'b0, 4'd2, 0, 0, 0);

        // Scoring at level 3
        pulse(1'b1, 1'b0);
        snap("food_in_start", START_SCR, 1'b0, 4'd2, 0, 0, 0);
        key(DIGIT_3);
        key(ENTER);
        repeat (3) pulse(1'b1, 1'b0);
        snap("score_9", GAME_SCR, 1'b1, 4'd3, 9, 0, 9);
        key(DIGIT_5);
        snap("digit_in_play", GAME_SCR, 1'b1, 4'd3, 9, 0, 9);
        pulse(1'b1, 1'b1);
        snap("food_and_over", END_SCR, 1'b0, 4'd3, 12, hs1, 12);
        key(MENU);
        snap("hs_retained", START_SCR, 1'b0, 4'd3, 12, hs1, 12);

        // Saturation on the 4-bit instance, high score update on the 12-bit one
        key(ENTER);
        snap("score_cleared", GAME_SCR, 1'b1, 4'd3, 0, hs1, 0);
        repeat (6) pulse(1'b1, 1'b0);
        snap("six_foods", GAME_SCR, 1'b1, 4'd3, 18, hs1, 15);
        pulse(1'b1, 1'b0);
        snap("seven_foods", GAME_SCR, 1'b1, 4'd3, 21, hs1, 15);
        pulse(1'b0, 1'b1);
        snap("second_over", END_SCR, 1'b0, 4'd3, 21, hs2, 15);
        key(MENU);

        // Asynchronous reset mid-PLAY
        key(ENTER);
        e = cyc;
        wait_to(e + 100);
        @(posedge CLOCK_50);
        #2;
        reset = 1'b1;
        snap("reset_mid_play", START_SCR, 1'b0, 4'd4, 0, 0, 0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        wait_to(cyc + 400);
        snap("after_reset_idle", START_SCR, 1'b0, 4'd4, 0, 0, 0);

        checks++;
        if (tick_q.size() != 0) begin
            failures++;
            $display("FAIL ticks_outstanding: %0d expected ticks never seen, required 0", tick_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
